// File: rtl/aud_i2s_codec_slave.sv
// aud_i2s_codec_slave
// I2S slave endpoint clocked entirely by MCLK. The master's AUD_BCLK and
// LRCK lines are oversampled through synchronizer chains. The DAC stream is
// deserialized into rx_left/rx_right. tx_left/tx_right are serialized onto
// AUD_ADCDAT, framed by the master's AUD_ADCLRCK.
// Optional build macro: AUD_SLAVE_STATUS_EN adds the rx_err and frame_cnt
// status outputs.
module aud_i2s_codec_slave #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             MCLK,
    input  logic             reset,
    input  logic             enable,
    input  logic             AUD_BCLK,
    input  logic             AUD_DACLRCK,
    input  logic             AUD_DACDAT,
    input  logic             AUD_ADCLRCK,
    output logic             AUD_ADCDAT,
    output logic [WIDTH-1:0] rx_left,
    output logic [WIDTH-1:0] rx_right,
    output logic             rx_valid,
    input  logic [WIDTH-1:0] tx_left,
    input  logic [WIDTH-1:0] tx_right,
    output logic             tx_load
`ifdef AUD_SLAVE_STATUS_EN
    ,
    output logic             rx_err,
    output logic [15:0]      frame_cnt
`endif
);

    // A single flop is never an adequate synchronizer, so the depth is clamped.
    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    // The counter must be able to hold WIDTH, which is the idle value.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_IDLE = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // Append one serial bit below the current shift-register contents.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] word,
                                                  input logic             bit_in);
        return {word[WIDTH-2:0], bit_in};
    endfunction

    // Synchronizer chains plus the previous synced BCLK level used for edge detection.
    logic [SS-1:0] bclk_sync_r;
    logic [SS-1:0] dac_lr_sync_r;
    logic [SS-1:0] dac_dat_sync_r;
    logic [SS-1:0] adc_lr_sync_r;
    logic          bclk_prev_r;

    // Synced views and the derived single-MCLK events.
    logic             bclk_s;
    logic             dac_lr_s;
    logic             dac_d_s;
    logic             adc_lr_s;
    logic             bclk_rise_s;
    logic             bclk_fall_s;
    logic             rx_lr_change_s;
    logic             tx_lr_change_s;
    logic             rx_done_s;
    logic [WIDTH-1:0] rx_word_s;
    logic             tx_bit_s;

    // Receive-side state.
    logic [WIDTH-1:0] rx_sh_r;
    logic [CW-1:0]    rx_cnt_r;
    logic             rx_ch_r;
    logic             prev_dac_lr_r;

    // Transmit-side state.
    logic [WIDTH-1:0] tx_buf_l_r;
    logic [WIDTH-1:0] tx_buf_r_r;
    logic [CW-1:0]    tx_cnt_r;
    logic             tx_ch_r;
    logic             prev_adc_lr_r;

    // Shift every asynchronous serial input through its own synchronizer chain.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            bclk_sync_r    <= {SS{1'b0}};
            dac_lr_sync_r  <= {SS{1'b0}};
            dac_dat_sync_r <= {SS{1'b0}};
            adc_lr_sync_r  <= {SS{1'b0}};
            bclk_prev_r    <= 1'b0;
        end else begin
            bclk_sync_r    <= {bclk_sync_r[SS-2:0], AUD_BCLK};
            dac_lr_sync_r  <= {dac_lr_sync_r[SS-2:0], AUD_DACLRCK};
            dac_dat_sync_r <= {dac_dat_sync_r[SS-2:0], AUD_DACDAT};
            adc_lr_sync_r  <= {adc_lr_sync_r[SS-2:0], AUD_ADCLRCK};
            bclk_prev_r    <= bclk_sync_r[SS-1];
        end
    end

    // Derive BCLK edges, word-select changes and the completing-word condition.
    always_comb begin
        bclk_s         = bclk_sync_r[SS-1];
        dac_lr_s       = dac_lr_sync_r[SS-1];
        dac_d_s        = dac_dat_sync_r[SS-1];
        adc_lr_s       = adc_lr_sync_r[SS-1];
        bclk_rise_s    = bclk_s & ~bclk_prev_r;
        bclk_fall_s    = ~bclk_s & bclk_prev_r;
        rx_lr_change_s = bclk_rise_s & (dac_lr_s != prev_dac_lr_r);
        tx_lr_change_s = bclk_rise_s & (adc_lr_s != prev_adc_lr_r);
        rx_word_s      = shift_in(rx_sh_r, dac_d_s);
        // A right word completes on the rise that carries its LSB.
        rx_done_s      = enable & bclk_rise_s & ~rx_lr_change_s & rx_ch_r
                         & (rx_cnt_r == CNT_LAST);
        if (tx_ch_r) begin
            tx_bit_s = tx_buf_r_r[WIDTH-1];
        end else begin
            tx_bit_s = tx_buf_l_r[WIDTH-1];
        end
    end

    // Receive deserializer: the word-select change rise is the I2S delay slot,
    // then WIDTH data bits are shifted in; any further bits are ignored.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            rx_sh_r       <= {WIDTH{1'b0}};
            rx_cnt_r      <= CNT_IDLE;
            rx_ch_r       <= 1'b0;
            prev_dac_lr_r <= 1'b1;
            rx_left       <= {WIDTH{1'b0}};
            rx_right      <= {WIDTH{1'b0}};
            rx_valid      <= 1'b0;
        end else begin
            rx_valid <= rx_done_s;
            if (!enable) begin
                // Keep tracking the word select so re-enabling waits for a real change.
                rx_cnt_r <= CNT_IDLE;
                if (bclk_rise_s) begin
                    prev_dac_lr_r <= dac_lr_s;
                end
            end else if (bclk_rise_s) begin
                prev_dac_lr_r <= dac_lr_s;
                if (rx_lr_change_s) begin
                    // New word; a partially received word is dropped here.
                    rx_cnt_r <= CNT_ZERO;
                    rx_ch_r  <= dac_lr_s;
                end else if (rx_cnt_r < CNT_IDLE) begin
                    rx_sh_r  <= rx_word_s;
                    rx_cnt_r <= rx_cnt_r + CNT_ONE;
                    if (rx_cnt_r == CNT_LAST) begin
                        if (rx_ch_r) begin
                            rx_right <= rx_word_s;
                        end else begin
                            rx_left <= rx_word_s;
                        end
                    end
                end
            end
        end
    end

    // Transmit serializer: latch both channels at left start, then present one
    // bit per BCLK falling edge so the master samples it on the following rise.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            tx_buf_l_r    <= {WIDTH{1'b0}};
            tx_buf_r_r    <= {WIDTH{1'b0}};
            tx_cnt_r      <= CNT_IDLE;
            tx_ch_r       <= 1'b0;
            prev_adc_lr_r <= 1'b1;
            AUD_ADCDAT    <= 1'b0;
            tx_load       <= 1'b0;
        end else begin
            tx_load <= 1'b0;
            if (!enable) begin
                tx_cnt_r   <= CNT_IDLE;
                AUD_ADCDAT <= 1'b0;
                if (bclk_rise_s) begin
                    prev_adc_lr_r <= adc_lr_s;
                end
            end else if (bclk_rise_s) begin
                prev_adc_lr_r <= adc_lr_s;
                if (tx_lr_change_s) begin
                    tx_cnt_r <= CNT_ZERO;
                    tx_ch_r  <= adc_lr_s;
                    if (!adc_lr_s) begin
                        tx_buf_l_r <= tx_left;
                        tx_buf_r_r <= tx_right;
                        tx_load    <= 1'b1;
                    end
                end
            end else if (bclk_fall_s) begin
                if (tx_cnt_r < CNT_IDLE) begin
                    AUD_ADCDAT <= tx_bit_s;
                    tx_cnt_r   <= tx_cnt_r + CNT_ONE;
                    if (tx_ch_r) begin
                        tx_buf_r_r <= {tx_buf_r_r[WIDTH-2:0], 1'b0};
                    end else begin
                        tx_buf_l_r <= {tx_buf_l_r[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    AUD_ADCDAT <= 1'b0;
                end
            end
        end
    end

`ifdef AUD_SLAVE_STATUS_EN
    logic rx_short_s;
    logic tx_short_s;

    // A word-select change before WIDTH bits were moved marks a short word.
    always_comb begin
        rx_short_s = enable & rx_lr_change_s & (rx_cnt_r < CNT_IDLE);
        tx_short_s = enable & tx_lr_change_s & (tx_cnt_r < CNT_IDLE);
    end

    // Pulse rx_err on short words and count completed stereo frames.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            rx_err    <= 1'b0;
            frame_cnt <= 16'h0000;
        end else begin
            rx_err <= rx_short_s | tx_short_s;
            if (rx_done_s) begin
                frame_cnt <= frame_cnt + 16'h0001;
            end
        end
    end
`endif

endmodule
